// File: rtl/pipe_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_decode_stage
//  Purpose  : Y86-64 PIPE decode stage. Selects source/destination register
//             ids for the instruction in the D pipeline register, reads the
//             register file, resolves operands through a five-source
//             forwarding network and holds the E pipeline register that
//             feeds execute. The register file is written from the W stage.
//  Ports    :
//    clk, rst                 clock / asynchronous active-high reset
//    D_icode, D_ifun          D-reg instruction and function codes
//    D_rA, D_rB               D-reg register specifier fields
//    D_valC, D_valP           D-reg constant word and incremented PC
//    D_stat                   D-reg status (passes through untouched)
//    e_dstE/e_valE            execute-stage E result (forwarding)
//    M_dstM/m_valM            memory-stage load result (forwarding)
//    M_dstE/M_valE            memory-stage E result (forwarding)
//    W_dstM/W_valM            writeback M result (forwarding + regfile write)
//    W_dstE/W_valE            writeback E result (forwarding + regfile write)
//    E_bubble                 load a NOP bubble into E on this edge
//    E_*                      E pipeline register contents
//    d_srcA/d_srcB            decoded source ids (combinational)
//    d_valA/d_valB            forwarded operand values (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [1:0]  D_stat,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic        E_bubble,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [63:0] E_valC,
  output logic [1:0]  E_stat,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);

  // Register ids and bubble opcode
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] NOP   = 4'h1;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int NUM_REGS = 15;

  logic [63:0] r_regFile [0:NUM_REGS-1];

  logic [3:0]  w_srcA;
  logic [3:0]  w_srcB;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_rfA;
  logic [63:0] w_rfB;
  logic [63:0] w_fwdA;
  logic [63:0] w_fwdB;
  logic [63:0] w_valA;

  // --------------------------------------------------------------------------
  // Register id selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_srcA = RNONE;
    unique case (D_icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: w_srcA = D_rA;
      IRET, IPOPQ:                    w_srcA = RSP;
      default:                        w_srcA = RNONE;
    endcase
  end

  always_comb begin
    w_srcB = RNONE;
    unique case (D_icode)
      IRMMOVQ, IMRMOVQ, IOPQ:      w_srcB = D_rB;
      ICALL, IRET, IPUSHQ, IPOPQ:  w_srcB = RSP;
      default:                     w_srcB = RNONE;
    endcase
  end

  // The cmov condition is not known yet; execute squashes dstE when it fails.
  always_comb begin
    w_dstE = RNONE;
    unique case (D_icode)
      IRRMOVQ, IIRMOVQ, IOPQ:      w_dstE = D_rB;
      ICALL, IRET, IPUSHQ, IPOPQ:  w_dstE = RSP;
      default:                     w_dstE = RNONE;
    endcase
  end

  always_comb begin
    w_dstM = RNONE;
    unique case (D_icode)
      IMRMOVQ, IPOPQ: w_dstM = D_rA;
      default:        w_dstM = RNONE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file: two write ports from W, two combinational read ports.
  // The M write is issued second so it takes precedence on an id collision.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regFile[i] <= '0;
      end
    end else begin
      if (W_dstE != RNONE) r_regFile[W_dstE] <= W_valE;
      if (W_dstM != RNONE) r_regFile[W_dstM] <= W_valM;
    end
  end

  // RNONE has no storage behind it and reads as zero.
  assign w_rfA = (w_srcA == RNONE) ? 64'd0 : r_regFile[w_srcA];
  assign w_rfB = (w_srcB == RNONE) ? 64'd0 : r_regFile[w_srcB];

  // --------------------------------------------------------------------------
  // Forwarding: youngest producer first. The W entries also cover the case
  // of a register being written and read in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fwdA = w_rfA;
    if (w_srcA == RNONE)       w_fwdA = 64'd0;
    else if (w_srcA == e_dstE) w_fwdA = e_valE;
    else if (w_srcA == M_dstM) w_fwdA = m_valM;
    else if (w_srcA == M_dstE) w_fwdA = M_valE;
    else if (w_srcA == W_dstM) w_fwdA = W_valM;
    else if (w_srcA == W_dstE) w_fwdA = W_valE;
  end

  always_comb begin
    w_fwdB = w_rfB;
    if (w_srcB == RNONE)       w_fwdB = 64'd0;
    else if (w_srcB == e_dstE) w_fwdB = e_valE;
    else if (w_srcB == M_dstM) w_fwdB = m_valM;
    else if (w_srcB == M_dstE) w_fwdB = M_valE;
    else if (w_srcB == W_dstM) w_fwdB = W_valM;
    else if (w_srcB == W_dstE) w_fwdB = W_valE;
  end

  // jXX and call carry the fall-through / return address in valA.
  assign w_valA = ((D_icode == IJXX) || (D_icode == ICALL)) ? D_valP : w_fwdA;

  assign d_srcA = w_srcA;
  assign d_srcB = w_srcB;
  assign d_valA = w_valA;
  assign d_valB = w_fwdB;

  // --------------------------------------------------------------------------
  // E pipeline register. Reset and bubble both leave a NOP in execute.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      E_icode <= NOP;
      E_ifun  <= 4'h0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_valC  <= 64'd0;
      E_stat  <= 2'd0;
    end else if (E_bubble) begin
      E_icode <= NOP;
      E_ifun  <= 4'h0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_valC  <= 64'd0;
      E_stat  <= 2'd0;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_dstE  <= w_dstE;
      E_dstM  <= w_dstM;
      E_srcA  <= w_srcA;
      E_srcB  <= w_srcB;
      E_valA  <= w_valA;
      E_valB  <= w_fwdB;
      E_valC  <= D_valC;
      E_stat  <= D_stat;
    end
  end

  // IHALT and INOP need no decode action beyond the defaults above.
  logic w_unusedCodes;
  assign w_unusedCodes = (D_icode == IHALT) | (D_icode == INOP);

endmodule
`default_nettype wire

// File: tb/tb_pipe_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_decode_stage
//  Purpose  : Self-checking bench for pipe_decode_stage: directed scenarios
//             plus randomized traffic compared against a behavioural model
//             (register array, rule-based id selection, forwarding chain).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_decode_stage;

  localparam logic [3:0] RNONE = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0]  D_stat;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic        E_bubble;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [1:0]  E_stat;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_valA, d_valB;

  int total = 0;
  int bad   = 0;

  logic [63:0] rf [16];   // entry 15 never used

  always #5 clk = ~clk;

  pipe_decode_stage dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .E_bubble(E_bubble),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_stat(E_stat),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_valA(d_valA), .d_valB(d_valB)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] mSrcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return RNONE;
  endfunction

  function automatic logic [3:0] mSrcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return RNONE;
  endfunction

  function automatic logic [3:0] mDstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return RNONE;
  endfunction

  function automatic logic [3:0] mDstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return RNONE;
  endfunction

  // Operand lookup: list of in-flight producers, youngest first, then regfile.
  function automatic logic [63:0] mRead(input logic [3:0] s);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    if (s == RNONE) return 64'd0;
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int k = 0; k < 5; k++)
      if (ids[k] == s) return vals[k];
    return rf[s];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 16; k++) rf[k] = 64'd0;
  endtask

  task automatic checkBubbleE(input string tag);
    check({tag, "_Eids"}, {40'd0, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB},
          {40'd0, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF});
    check({tag, "_Evals"}, E_valA | E_valB | E_valC, 64'd0);
    check({tag, "_Estat"}, {62'd0, E_stat}, 64'd0);
  endtask

  // One clock: inputs are already driven. Check decode outputs at the
  // falling edge, then the E register and model state after the rising edge.
  task automatic cycle();
    logic [3:0]  sA, sB, dE, dM;
    logic [63:0] vA, vB;
    logic [3:0]  xIc, xIf;
    logic [1:0]  xSt;
    logic [63:0] xC;
    logic        bub;
    sA = mSrcA(D_icode, D_rA);
    sB = mSrcB(D_icode, D_rB);
    dE = mDstE(D_icode, D_rB);
    dM = mDstM(D_icode, D_rA);
    vA = (D_icode inside {4'h7, 4'h8}) ? D_valP : mRead(sA);
    vB = mRead(sB);
    xIc = D_icode; xIf = D_ifun; xSt = D_stat; xC = D_valC; bub = E_bubble;
    @(negedge clk);
    check("d_srcA", {60'd0, d_srcA}, {60'd0, sA});
    check("d_srcB", {60'd0, d_srcB}, {60'd0, sB});
    check("d_valA", d_valA, vA);
    check("d_valB", d_valB, vB);
    @(posedge clk);
    if (W_dstE != RNONE) rf[W_dstE] = W_valE;
    if (W_dstM != RNONE) rf[W_dstM] = W_valM;
    #1;
    if (bub) begin
      checkBubbleE("bubble");
    end else begin
      check("E_ids", {40'd0, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB},
            {40'd0, xIc, xIf, dE, dM, sA, sB});
      check("E_valA", E_valA, vA);
      check("E_valB", E_valB, vB);
      check("E_valC", E_valC, xC);
      check("E_stat", {62'd0, E_stat}, {62'd0, xSt});
    end
  endtask

  task automatic idle();
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = RNONE; D_rB = RNONE;
    D_valC = 64'd0; D_valP = 64'd0; D_stat = 2'd0;
    e_dstE = RNONE; M_dstM = RNONE; M_dstE = RNONE; W_dstM = RNONE; W_dstE = RNONE;
    e_valE = 64'd0; m_valM = 64'd0; M_valE = 64'd0; W_valM = 64'd0; W_valE = 64'd0;
    E_bubble = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic randomize_inputs();
    D_icode = 4'($urandom_range(0, 15));
    D_ifun  = 4'($urandom_range(0, 15));
    D_rA    = 4'($urandom_range(0, 15));
    D_rB    = 4'($urandom_range(0, 15));
    D_valC  = rnd64(); D_valP = rnd64();
    D_stat  = 2'($urandom_range(0, 3));
    e_dstE  = 4'($urandom_range(0, 15)); e_valE = rnd64();
    M_dstM  = 4'($urandom_range(0, 15)); m_valM = rnd64();
    M_dstE  = 4'($urandom_range(0, 15)); M_valE = rnd64();
    W_dstM  = 4'($urandom_range(0, 15)); W_valM = rnd64();
    W_dstE  = 4'($urandom_range(0, 15)); W_valE = rnd64();
    E_bubble = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    // ---------------- reset ----------------
    idle();
    D_icode = 4'h6; D_stat = 2'd2;
    rst = 1'b1;
    modelReset();
    @(posedge clk); #1;
    checkBubbleE("reset");
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(posedge clk); #1;

    // ---------------- irmovq writes r2 via W, then read back ----------------
    D_icode = 4'h3; D_rA = RNONE; D_rB = 4'h2; D_valC = 64'd10;
    W_dstE = 4'h2; W_valE = 64'd10;
    cycle();
    idle();
    D_icode = 4'h2; D_rA = 4'h2; D_rB = 4'h7;
    #1 check("dir_rrmovq_valA", d_valA, 64'd10);
    cycle();

    // ---------------- OPq: e beats M ----------------
    idle();
    D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h4;
    e_dstE = 4'h3; e_valE = 64'd5; M_dstE = 4'h3; M_valE = 64'd9;
    #1;
    check("dir_opq_valA", d_valA, 64'd5);
    check("dir_opq_srcB", {60'd0, d_srcB}, 64'd4);
    cycle();

    // ---------------- call ----------------
    idle();
    D_icode = 4'h8; D_valP = 64'h40;
    #1;
    check("dir_call_valA", d_valA, 64'h40);
    check("dir_call_srcB", {60'd0, d_srcB}, 64'd4);
    cycle();
    check("dir_call_EdstE", {60'd0, E_dstE}, 64'd4);

    // ---------------- popq ----------------
    idle();
    D_icode = 4'hB; D_rA = 4'h1; D_rB = RNONE;
    #1;
    check("dir_pop_srcs", {56'd0, d_srcA, d_srcB}, 64'h44);
    cycle();
    check("dir_pop_Edst", {56'd0, E_dstE, E_dstM}, 64'h41);

    // ---------------- M beats E on same-id writeback ----------------
    idle();
    W_dstE = 4'h6; W_valE = 64'h1111; W_dstM = 4'h6; W_valM = 64'h2222;
    cycle();
    idle();
    D_icode = 4'h2; D_rA = 4'h6;
    #1 check("dir_wb_order", d_valA, 64'h2222);
    cycle();

    // ---------------- bubble over halt ----------------
    idle();
    D_icode = 4'h0; D_stat = 2'd1; E_bubble = 1'b1;
    cycle();
    check("dir_bubble_icode", {60'd0, E_icode}, 64'd1);
    check("dir_bubble_dstE", {60'd0, E_dstE}, 64'hF);
    check("dir_bubble_stat", {62'd0, E_stat}, 64'd0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      cycle();
    end

    // ---------------- asynchronous reset mid-stream ----------------
    idle();
    for (int r = 0; r < 15; r++) begin
      W_dstE = 4'(r); W_valE = 64'hA5A5_0000 + 64'(r);
      cycle();
    end
    idle();
    D_icode = 4'h6; D_rA = 4'h5; D_rB = 4'h9; D_stat = 2'd3;
    cycle();
    #2 rst = 1'b1;
    modelReset();
    #1 checkBubbleE("midrst");
    D_icode = 4'h2; D_rA = 4'h5;
    #1 check("midrst_rf_read", d_valA, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 100; n++) begin
      randomize_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
